conv_core_mc_acc: RTL and testbench

Parametrised, channel-serial successor of the fixed 2x2/3-channel convolution core. It accepts one input channel per beat over a valid/ready handshake. Each beat carries a K x (K+NPOS-1) image window and a K x K filter. The block computes NPOS adjacent output positions, accumulates across up to C channels, applies optional ReLU and saturation, and holds the result under a second valid/ready handshake. It sits between the SPI-fed window buffer and the result collector, in the clk_spi domain.

---
 rtl/conv_pkg.sv | 48 ++++
 rtl/conv_window_dot.sv | 28 ++
 rtl/conv_core_mc_acc.sv | 180 ++++++++++++++++++
 tb/tb_conv_core_mc_acc.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared defaults, FSM state encoding and output post-processing for the
// channel-serial convolution core.
package conv_pkg;

  localparam int unsigned DEF_DW    = 8;
  localparam int unsigned DEF_K     = 2;
  localparam int unsigned DEF_NPOS  = 4;
  localparam int unsigned DEF_C     = 3;
  localparam int unsigned DEF_ACC_W = 24;
  localparam int unsigned DEF_OUT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_e;

  // Clamp bounds expressed at accumulator width
  localparam logic [DEF_ACC_W-1:0] SAT_SMAX = DEF_ACC_W'((64'd1 << (DEF_OUT_W - 1)) - 64'd1);
  localparam logic [DEF_ACC_W-1:0] SAT_SMIN = ~SAT_SMAX;
  localparam logic [DEF_ACC_W-1:0] SAT_UMAX = DEF_ACC_W'((64'd1 << DEF_OUT_W) - 64'd1);

  // ReLU (signed only) followed by saturation to the output lane width
  function automatic logic [DEF_OUT_W-1:0] sat_relu(
    input logic [DEF_ACC_W-1:0] acc,
    input logic                 is_signed,
    input logic                 relu
  );
    logic signed [DEF_ACC_W-1:0] s_acc;
    logic [DEF_OUT_W-1:0]        res;
    s_acc = signed'(acc);
    res   = acc[DEF_OUT_W-1:0];
    if (is_signed) begin
      if (relu && acc[DEF_ACC_W-1]) begin
        res = '0;
      end else if (s_acc > signed'(SAT_SMAX)) begin
        res = DEF_OUT_W'(SAT_SMAX);
      end else if (s_acc < signed'(SAT_SMIN)) begin
        res = DEF_OUT_W'(SAT_SMIN);
      end
    end else if (acc > SAT_UMAX) begin
      res = DEF_OUT_W'(SAT_UMAX);
    end
    return res;
  endfunction

endpackage

// File: rtl/conv_window_dot.sv
// One output lane: K*K multiply-accumulate over a kernel-sized window,
// purely combinational, operands sign- or zero-extended to ACC_W.
module conv_window_dot
  import conv_pkg::*;
#(
  parameter int unsigned DW    = DEF_DW,
  parameter int unsigned K     = DEF_K,
  parameter int unsigned ACC_W = DEF_ACC_W
) (
  input  logic [DW*K*K-1:0] i_win,
  input  logic [DW*K*K-1:0] i_flt,
  input  logic              i_signed,
  output logic [ACC_W-1:0]  o_dot_c
);

  function automatic logic [ACC_W-1:0] ext(input logic [DW-1:0] v, input logic s);
    return {{(ACC_W - DW){s & v[DW-1]}}, v};
  endfunction

  // Low ACC_W bits of the products are exact for both signednesses
  always_comb begin
    o_dot_c = '0;
    for (int i = 0; i < int'(K * K); i++) begin
      o_dot_c = o_dot_c + ext(i_win[DW*i +: DW], i_signed) * ext(i_flt[DW*i +: DW], i_signed);
    end
  end

endmodule

// File: rtl/conv_core_mc_acc.sv
// Channel-serial convolution core: NPOS lanes per beat, accumulation over up
// to C channels, ReLU/saturation, and a held result behind valid/ready.
module conv_core_mc_acc
  import conv_pkg::*;
#(
  parameter int unsigned DW    = DEF_DW,
  parameter int unsigned K     = DEF_K,
  parameter int unsigned NPOS  = DEF_NPOS,
  parameter int unsigned C     = DEF_C,
  parameter int unsigned ACC_W = DEF_ACC_W,
  parameter int unsigned OUT_W = DEF_OUT_W
) (
  input  logic                           clk_spi,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_last,
  input  logic [DW*K*(K+NPOS-1)-1:0]     image,
  input  logic [DW*K*K-1:0]              filter,
  input  logic                           cfg_signed,
  input  logic                           cfg_relu,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [OUT_W*NPOS-1:0]          conv_out,
  output logic                           out_trunc,
  output logic [$clog2(C+1)-1:0]         out_chans,
  output logic                           busy
);

  localparam int unsigned WIN_W = K + NPOS - 1;
  localparam int unsigned KK    = K * K;
  localparam int unsigned CH_W  = $clog2(C + 1);

  state_e               r_state;
  state_e               w_state_nxt;
  logic                 r_drain;
  logic                 w_accept;
  logic                 w_frame_end;
  logic                 w_op_signed;
  logic                 w_res_load;
  logic [CH_W-1:0]      w_ch_nxt;
  logic [CH_W-1:0]      r_ch_cnt;
  logic                 r_signed;
  logic                 r_relu;
  logic                 r_trunc_pend;
  logic                 r_prod_vld;
  logic                 r_prod_first;
  logic [DW*KK-1:0]     w_win  [NPOS];
  logic [ACC_W-1:0]     w_dot  [NPOS];
  logic [ACC_W-1:0]     r_prod [NPOS];
  logic [ACC_W-1:0]     r_acc  [NPOS];
  logic [OUT_W*NPOS-1:0] r_conv_out;
  logic                 r_out_valid;
  logic                 r_out_trunc;
  logic [CH_W-1:0]      r_out_chans;

  assign in_ready  = (r_state == IDLE) || (r_state == ACCUM);
  assign busy      = (r_state != IDLE);
  assign out_valid = r_out_valid;
  assign conv_out  = r_conv_out;
  assign out_trunc = r_out_trunc;
  assign out_chans = r_out_chans;

  assign w_accept    = in_valid & in_ready;
  assign w_ch_nxt    = (r_state == IDLE) ? CH_W'(1) : r_ch_cnt + CH_W'(1);
  assign w_frame_end = w_accept & (in_last | (w_ch_nxt == CH_W'(C)));
  // First beat uses the live config; later beats use the frame's sampled copy
  assign w_op_signed = (r_state == IDLE) ? cfg_signed : r_signed;
  assign w_res_load  = (r_state == DRAIN) && r_drain;

  // Slide the K x K window along the wide image for each lane
  always_comb begin
    for (int p = 0; p < int'(NPOS); p++) begin
      w_win[p] = '0;
      for (int r = 0; r < int'(K); r++) begin
        for (int c = 0; c < int'(K); c++) begin
          w_win[p][DW*(r*int'(K)+c) +: DW] = image[DW*(r*int'(WIN_W)+p+c) +: DW];
        end
      end
    end
  end

  for (genvar p = 0; p < int'(NPOS); p++) begin : g_lane
    conv_window_dot #(
      .DW    (DW),
      .K     (K),
      .ACC_W (ACC_W)
    ) u_dot (
      .i_win    (w_win[p]),
      .i_flt    (filter),
      .i_signed (w_op_signed),
      .o_dot_c  (w_dot[p])
    );
  end

  always_ff @(posedge clk_spi or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_frame_end)   w_state_nxt = DRAIN;
        else if (w_accept) w_state_nxt = ACCUM;
      end
      ACCUM: begin
        if (w_frame_end) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (r_drain) w_state_nxt = OUT;
      end
      OUT: begin
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Beat capture: products, channel count and frame-level configuration
  always_ff @(posedge clk_spi or negedge rst_n) begin
    if (!rst_n) begin
      r_drain      <= 1'b0;
      r_ch_cnt     <= '0;
      r_signed     <= 1'b0;
      r_relu       <= 1'b0;
      r_trunc_pend <= 1'b0;
      r_prod_vld   <= 1'b0;
      r_prod_first <= 1'b0;
      for (int p = 0; p < int'(NPOS); p++) r_prod[p] <= '0;
    end else begin
      r_drain    <= (r_state == DRAIN) && !r_drain;
      r_prod_vld <= w_accept;
      if (w_accept) begin
        r_ch_cnt     <= w_ch_nxt;
        r_prod_first <= (r_state == IDLE);
        for (int p = 0; p < int'(NPOS); p++) r_prod[p] <= w_dot[p];
        if (r_state == IDLE) begin
          r_signed <= cfg_signed;
          r_relu   <= cfg_relu;
        end
        if (w_frame_end) r_trunc_pend <= ~in_last;
      end
    end
  end

  always_ff @(posedge clk_spi or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < int'(NPOS); p++) r_acc[p] <= '0;
    end else if (r_prod_vld) begin
      for (int p = 0; p < int'(NPOS); p++) begin
        r_acc[p] <= r_prod_first ? r_prod[p] : r_acc[p] + r_prod[p];
      end
    end
  end

  // Result register: loaded at the end of DRAIN, held until consumed
  always_ff @(posedge clk_spi or negedge rst_n) begin
    if (!rst_n) begin
      r_conv_out  <= '0;
      r_out_valid <= 1'b0;
      r_out_trunc <= 1'b0;
      r_out_chans <= '0;
    end else if (w_res_load) begin
      for (int p = 0; p < int'(NPOS); p++) begin
        r_conv_out[OUT_W*p +: OUT_W] <= sat_relu(r_acc[p], r_signed, r_relu);
      end
      r_out_valid <= 1'b1;
      r_out_trunc <= r_trunc_pend;
      r_out_chans <= r_ch_cnt;
    end else if ((r_state == OUT) && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_core_mc_acc.sv
// Directed bench for conv_core_mc_acc: stimulus pushes expected results into
// a queue, an independent monitor pops them on each output handshake.
module tb_conv_core_mc_acc;

  logic        clk_spi;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [79:0] image;
  logic [31:0] filter;
  logic        cfg_signed;
  logic        cfg_relu;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] conv_out;
  logic        out_trunc;
  logic [1:0]  out_chans;
  logic        busy;

  typedef struct {
    logic [63:0] data;
    logic        trunc;
    logic [1:0]  chans;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  conv_core_mc_acc dut (
    .clk_spi    (clk_spi),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_last    (in_last),
    .image      (image),
    .filter     (filter),
    .cfg_signed (cfg_signed),
    .cfg_relu   (cfg_relu),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .conv_out   (conv_out),
    .out_trunc  (out_trunc),
    .out_chans  (out_chans),
    .busy       (busy)
  );

  initial clk_spi = 1'b0;
  always #5 clk_spi = ~clk_spi;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare every consumed result against the scoreboard head
  always @(negedge clk_spi) begin
    exp_t e;
    #1;
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_result", {63'd0, out_valid}, 64'd0);
      end else begin
        e = q.pop_front();
        chk("conv_out", conv_out, e.data);
        chk("out_trunc", {63'd0, out_trunc}, {63'd0, e.trunc});
        chk("out_chans", {62'd0, out_chans}, {62'd0, e.chans});
      end
    end
  end

  // Present one beat at a negedge, return at the negedge after acceptance
  task automatic beat(input logic [7:0] iv, input logic [7:0] fv, input logic last);
    int n = 0;
    image    = {10{iv}};
    filter   = {4{fv}};
    in_last  = last;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk_spi);
      n++;
    end
    if (!in_ready) chk("beat_accept_timeout", {63'd0, in_ready}, 64'd1);
    @(posedge clk_spi);
    @(negedge clk_spi);
    in_valid = 1'b0;
  endtask

  task automatic frame(input logic [7:0] iv, input logic [7:0] fv, input int nb,
                       input logic with_last, input logic sgn, input logic relu,
                       input logic [15:0] lane, input logic trunc, input logic [1:0] chans);
    exp_t e;
    e.data  = {4{lane}};
    e.trunc = trunc;
    e.chans = chans;
    q.push_back(e);
    cfg_signed = sgn;
    cfg_relu   = relu;
    for (int b = 0; b < nb; b++) beat(iv, fv, with_last && (b == nb - 1));
  endtask

  task automatic wait_drained();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk_spi);
      n++;
    end
    if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'd0);
    @(negedge clk_spi);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_busy"},      {63'd0, busy},      64'd0);
    chk({tag, "_conv_out"},  conv_out,           64'd0);
    chk({tag, "_out_trunc"}, {63'd0, out_trunc}, 64'd0);
    chk({tag, "_out_chans"}, {62'd0, out_chans}, 64'd0);
    chk({tag, "_in_ready"},  {63'd0, in_ready},  64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_last    = 1'b0;
    image      = '0;
    filter     = '0;
    cfg_signed = 1'b0;
    cfg_relu   = 1'b0;
    out_ready  = 1'b1;
    @(negedge clk_spi);
    @(negedge clk_spi);
    chk_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk_spi);

    // Unsigned 3-channel sum of ones, with latency checks
    frame(8'h01, 8'h01, 3, 1'b1, 1'b0, 1'b0, 16'h000C, 1'b0, 2'd3);
    chk("lat_t0_valid", {63'd0, out_valid}, 64'd0);
    chk("lat_t0_busy",  {63'd0, busy},      64'd1);
    @(negedge clk_spi);
    chk("lat_t1_valid", {63'd0, out_valid}, 64'd0);
    @(negedge clk_spi);
    chk("lat_t2_valid", {63'd0, out_valid}, 64'd1);
    wait_drained();

    // Signed -1 x 2 over two channels, without and with ReLU
    frame(8'hFF, 8'h02, 2, 1'b1, 1'b1, 1'b0, 16'hFFF0, 1'b0, 2'd2);
    frame(8'hFF, 8'h02, 2, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 2'd2);
    wait_drained();

    // Saturation: unsigned high and signed positive overflow
    frame(8'hFF, 8'hFF, 1, 1'b1, 1'b0, 1'b0, 16'hFFFF, 1'b0, 2'd1);
    frame(8'h80, 8'h80, 3, 1'b1, 1'b1, 1'b0, 16'h7FFF, 1'b0, 2'd3);
    wait_drained();

    // Forced end at C beats; next beat must wait for IDLE
    frame(8'h01, 8'h01, 3, 1'b0, 1'b0, 1'b0, 16'h000C, 1'b1, 2'd3);
    chk("force_in_ready", {63'd0, in_ready}, 64'd0);
    frame(8'h01, 8'h01, 1, 1'b1, 1'b0, 1'b0, 16'h0004, 1'b0, 2'd1);
    wait_drained();

    // Output backpressure with a pending input beat held upstream
    out_ready = 1'b0;
    frame(8'h01, 8'h01, 1, 1'b1, 1'b0, 1'b0, 16'h0004, 1'b0, 2'd1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk_spi);
      n++;
    end
    chk("bp_wait_valid", {63'd0, out_valid}, 64'd1);
    begin
      exp_t e;
      e.data  = {4{16'h0018}};
      e.trunc = 1'b0;
      e.chans = 2'd1;
      q.push_back(e);
    end
    image    = {10{8'h02}};
    filter   = {4{8'h03}};
    in_last  = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_conv_out",  conv_out,              {4{16'h0004}});
      chk("bp_in_ready",  {63'd0, in_ready},     64'd0);
      chk("bp_out_valid", {63'd0, out_valid},    64'd1);
      @(negedge clk_spi);
    end
    out_ready = 1'b1;
    @(negedge clk_spi);
    chk("bp_release_valid", {63'd0, out_valid}, 64'd0);
    chk("bp_release_ready", {63'd0, in_ready},  64'd1);
    beat(8'h02, 8'h03, 1'b1);
    wait_drained();

    // Reset mid-frame discards the partial result
    cfg_signed = 1'b0;
    cfg_relu   = 1'b0;
    beat(8'h01, 8'h01, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_reset_values("midrst");
    @(negedge clk_spi);
    rst_n = 1'b1;
    @(negedge clk_spi);
    frame(8'h01, 8'h01, 1, 1'b1, 1'b0, 1'b0, 16'h0004, 1'b0, 2'd1);
    wait_drained();

    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
